// File: rtl/uart_rx_control_pkg.sv
// uart_rx_control_pkg: receiver state encoding and baud presets shared with the transmit path.
package uart_rx_control_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_t;
    localparam int BPS_9600   = 5208;
    localparam int BPS_115200 = 434;
endpackage

// File: rtl/uart_rx_control_sync_edge.sv
// rx_sync_edge: two-flop synchroniser for the RX pin plus falling-edge detector.
module rx_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic rx_pin,
    output logic rx_s,
    output logic fall
);
    logic rx_m, rx_d;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx_pin;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end
    assign fall = rx_d & ~rx_s;
endmodule

// File: rtl/uart_rx_control.sv
// uart_rx_control: 8N1 UART receiver with mid-bit sampling, done and framing-error pulses.
module uart_rx_control import uart_rx_control_pkg::*; #(
    parameter int BPS_CNT  = BPS_9600,
    parameter int HALF_CNT = BPS_CNT / 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    output logic [7:0] RX_Data,
    output logic       RX_Done_Sig,
    output logic       RX_Err_Sig,
    output logic       RX_Busy
);
    localparam logic [12:0] CNT_MAX = 13'(BPS_CNT - 1);
    localparam logic [12:0] CNT_MID = 13'(HALF_CNT);
    rx_state_t   state, state_n;
    logic [12:0] cnt, cnt_n;
    logic [2:0]  n, n_n;
    logic [7:0]  shift, shift_n, data_n;
    logic        done_n, err_n, rx_s, fall, strobe;
    rx_sync_edge u_sync (.CLK(CLK), .RST(RST), .rx_pin(RX_Pin_In), .rx_s(rx_s), .fall(fall));
    assign strobe  = cnt == CNT_MID;
    assign RX_Busy = state != IDLE;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            n           <= '0;
            shift       <= '0;
            RX_Data     <= '0;
            RX_Done_Sig <= 1'b0;
            RX_Err_Sig  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            n           <= n_n;
            shift       <= shift_n;
            RX_Data     <= data_n;
            RX_Done_Sig <= done_n;
            RX_Err_Sig  <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE || cnt == CNT_MAX) ? 13'd0 : cnt + 13'd1;
        n_n     = n;
        shift_n = shift;
        data_n  = RX_Data;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (!RX_En_Sig) begin
            state_n = IDLE;
            cnt_n   = 13'd0;
        end else begin
            case (state)
                IDLE: if (fall) begin
                    state_n = START;
                    n_n     = 3'd0;
                end
                START: if (strobe) state_n = rx_s ? IDLE : DATA;
                DATA: if (strobe) begin
                    shift_n = {rx_s, shift[7:1]};
                    n_n     = n + 3'd1;
                    state_n = (n == 3'd7) ? STOP : DATA;
                end
                STOP: if (strobe) begin
                    state_n = IDLE;
                    data_n  = rx_s ? shift : RX_Data;
                    done_n  = rx_s;
                    err_n   = ~rx_s;
                end
            endcase
        end
    end
endmodule
